// File: rtl/pal_timing_generator.sv
// PAL raster timing source, clocked at 16x the colour subcarrier.
// Generates sync/blank/burst/burst-phase for the composite DAC stage and
// pixel/line coordinates plus an active-video strobe for the colour source.
// Every output is registered from the pre-edge counter values.
// Optional feature: define PAL_TIMING_INTERLACE_EN for a 625-line interlaced
// frame (two fields); otherwise the frame is 312 progressive lines.
module pal_timing_generator #(
  parameter int LINE_CLOCKS  = 4540,
  parameter int HSYNC_CLOCKS = 333,
  parameter int BURST_START  = 397,
  parameter int BURST_CLOCKS = 160,
  parameter int ACTIVE_START = 851,
  parameter int FRONT_PORCH  = 117,
  parameter int BROAD_CLOCKS = 1937,
  parameter int EQ_CLOCKS    = 167
) (
  input  logic        phaseClock,
  input  logic        resetN,
  output logic [3:0]  subcarrierPhase,
  output logic        sync,
  output logic        blank,
  output logic        burst,
  output logic        burstPhase,
  output logic        activeVideo,
  output logic [11:0] pixelX,
  output logic [9:0]  lineNumber,
  output logic        field,
  output logic        frameStart
);

`ifdef PAL_TIMING_INTERLACE_EN
  localparam int FRAME_LINES = 625;
  localparam int LAST_KK     = 624;
`else
  localparam int FRAME_LINES = 312;
  localparam int LAST_KK     = 623;
`endif

  localparam logic [12:0] H_LAST   = 13'(LINE_CLOCKS - 1);
  localparam logic [12:0] H_HALF   = 13'(LINE_CLOCKS / 2);
  localparam logic [12:0] H_SYNC   = 13'(HSYNC_CLOCKS);
  localparam logic [12:0] H_BST0   = 13'(BURST_START);
  localparam logic [12:0] H_BST1   = 13'(BURST_START + BURST_CLOCKS);
  localparam logic [12:0] H_ACT    = 13'(ACTIVE_START);
  localparam logic [12:0] H_FP     = 13'(LINE_CLOCKS - FRONT_PORCH);
  localparam logic [12:0] H_BROAD  = 13'(BROAD_CLOCKS);
  localparam logic [12:0] H_EQ     = 13'(EQ_CLOCKS);
  localparam logic [9:0]  L_LAST   = 10'(FRAME_LINES - 1);
  localparam logic [10:0] KK_EQ_T  = 11'(LAST_KK - 4);
  localparam logic [10:0] KK_VID_T = 11'(LAST_KK - 5);

  logic [12:0] h_count;
  logic [9:0]  line_count;
  logic [3:0]  phase_cnt;
  logic        bp_line;

  logic        half;
  logic [12:0] hh;
  logic [10:0] k;
  logic [10:0] kk;
  logic        fld;
  logic        is_broad;
  logic        is_eq;
  logic        sync_d;
  logic        blank_d;
  logic        burst_d;
  logic [11:0] px_d;

  // Raster counters: free-running phase, line position, per-line V-switch.
  always_ff @(posedge phaseClock or negedge resetN) begin
    if (!resetN) begin
      h_count    <= '0;
      line_count <= '0;
      phase_cnt  <= '0;
      bp_line    <= 1'b1;
    end else begin
      phase_cnt <= phase_cnt + 4'd1;
      if (h_count == H_LAST) begin
        h_count    <= '0;
        bp_line    <= ~bp_line;
        line_count <= (line_count == L_LAST) ? '0 : line_count + 10'd1;
      end else begin
        h_count <= h_count + 13'd1;
      end
    end
  end

  // Half-line classification and waveform decode of the current position.
  always_comb begin
    half = (h_count >= H_HALF);
    hh   = half ? (h_count - H_HALF) : h_count;
    k    = {line_count, half};
`ifdef PAL_TIMING_INTERLACE_EN
    fld  = (k >= 11'd625);
    kk   = fld ? (k - 11'd625) : k;
`else
    fld  = 1'b0;
    kk   = k;
`endif
    is_broad = (kk <= 11'd4);
    is_eq    = ((kk >= 11'd5) && (kk <= 11'd9)) || (kk >= KK_EQ_T);
    if (is_broad)
      sync_d = (hh < H_BROAD);
    else if (is_eq)
      sync_d = (hh < H_EQ);
    else
      sync_d = !half && (h_count < H_SYNC);
    blank_d = (kk < 11'd46) || (kk > KK_VID_T) ||
              (h_count < H_ACT) || (h_count >= H_FP);
    burst_d = !is_broad && !is_eq && !half &&
              (kk >= 11'd10) && (kk <= KK_VID_T) &&
              (h_count >= H_BST0) && (h_count < H_BST1);
    px_d    = blank_d ? 12'd0 : 12'(h_count - H_ACT);
  end

  // Output register stage, one clock behind the counters.
  always_ff @(posedge phaseClock or negedge resetN) begin
    if (!resetN) begin
      subcarrierPhase <= '0;
      sync            <= 1'b0;
      blank           <= 1'b1;
      burst           <= 1'b0;
      burstPhase      <= 1'b1;
      activeVideo     <= 1'b0;
      pixelX          <= '0;
      lineNumber      <= '0;
      field           <= 1'b0;
      frameStart      <= 1'b0;
    end else begin
      subcarrierPhase <= phase_cnt;
      sync            <= sync_d;
      blank           <= blank_d;
      burst           <= burst_d;
      burstPhase      <= bp_line;
      activeVideo     <= !blank_d;
      pixelX          <= px_d;
      lineNumber      <= line_count;
      field           <= fld;
      frameStart      <= (h_count == 13'd0) && (line_count == 10'd0);
    end
  end

endmodule

// File: tb/tb_pal_timing_generator.sv
// Bench for pal_timing_generator using a shortened line (200 clocks) so a
// whole progressive frame fits in a short run; all other timing is scaled.
module tb_pal_timing_generator;

  localparam int LC   = 200;
  localparam int HS   = 14;
  localparam int BS   = 18;
  localparam int BC   = 8;
  localparam int AS   = 40;
  localparam int FP   = 6;
  localparam int BRD  = 85;
  localparam int EQ   = 7;
  localparam int HALF = LC / 2;
`ifdef PAL_TIMING_INTERLACE_EN
  localparam int FRAME = 625;
  localparam int LAST  = 624;
`else
  localparam int FRAME = 312;
  localparam int LAST  = 623;
`endif

  logic        phaseClock;
  logic        resetN;
  logic [3:0]  subcarrierPhase;
  logic        sync, blank, burst, burstPhase, activeVideo, field, frameStart;
  logic [11:0] pixelX;
  logic [9:0]  lineNumber;

  pal_timing_generator #(
    .LINE_CLOCKS(LC), .HSYNC_CLOCKS(HS), .BURST_START(BS), .BURST_CLOCKS(BC),
    .ACTIVE_START(AS), .FRONT_PORCH(FP), .BROAD_CLOCKS(BRD), .EQ_CLOCKS(EQ)
  ) dut (
    .phaseClock(phaseClock), .resetN(resetN),
    .subcarrierPhase(subcarrierPhase), .sync(sync), .blank(blank),
    .burst(burst), .burstPhase(burstPhase), .activeVideo(activeVideo),
    .pixelX(pixelX), .lineNumber(lineNumber), .field(field),
    .frameStart(frameStart)
  );

  initial phaseClock = 1'b0;
  always #5 phaseClock = ~phaseClock;

  typedef struct packed {
    logic [3:0]  scp;
    logic        sync;
    logic        blank;
    logic        burst;
    logic        bph;
    logic        act;
    logic [11:0] px;
    logic [9:0]  ln;
    logic        fld;
    logic        fs;
  } outs_t;

  typedef struct {
    outs_t o;
    int    line;
    int    h;
  } sb_t;

  typedef struct {
    int line;
    int h;
    int scp;
    bit sync;
    bit blank;
    bit burst;
    bit act;
    int px;
    bit bph;
  } vec_t;

  sb_t   sb[$];
  vec_t  tbl[29];
  int    nerr = 0;
  int    nchecks = 0;
  int    cur_line = -1;
  int    cur_h = -1;
  int    cyc = 0;
  int    m_line, m_h, m_ph;
  bit    m_bp;

  function automatic outs_t sample();
    return {subcarrierPhase, sync, blank, burst, burstPhase, activeVideo,
            pixelX, lineNumber, field, frameStart};
  endfunction

  function automatic outs_t model(input int line, input int h, input int ph, input bit bp);
    outs_t o;
    int half, hh, k, kk;
    bit fld, broad, eq, blk;
    half = (h >= HALF) ? 1 : 0;
    hh   = h % HALF;
    k    = 2 * line + half;
    fld  = (FRAME == 625) && (k >= 625);
    kk   = fld ? k - 625 : k;
    broad = (kk <= 4);
    eq    = (kk >= 5 && kk <= 9) || (kk >= LAST - 4 && kk <= LAST);
    blk   = (kk < 46) || (kk > LAST - 5) || (h < AS) || (h >= LC - FP);
    o.scp   = 4'(ph);
    o.sync  = broad ? (hh < BRD) : eq ? (hh < EQ) : (half == 0 && h < HS);
    o.blank = blk;
    o.burst = !broad && !eq && half == 0 && kk >= 10 && kk <= LAST - 5 &&
              h >= BS && h < BS + BC;
    o.bph   = bp;
    o.act   = !blk;
    o.px    = blk ? 12'd0 : 12'(h - AS);
    o.ln    = 10'(line);
    o.fld   = fld;
    o.fs    = (line == 0 && h == 0);
    return o;
  endfunction

  task automatic check(input string name, input outs_t got, input outs_t want);
    nchecks++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s at line %0d h %0d: got %h required %h", name, cur_line, cur_h, got, want);
    end
  endtask

  task automatic model_reset();
    m_line = 0; m_h = 0; m_ph = 0; m_bp = 1'b1;
  endtask

  // One clock: push the expectation for the pre-edge position, then compare.
  task automatic cycle();
    sb_t e;
    @(posedge phaseClock);
    e.o = model(m_line, m_h, m_ph, m_bp);
    e.line = m_line;
    e.h = m_h;
    sb.push_back(e);
    m_ph = (m_ph + 1) % 16;
    if (m_h == LC - 1) begin
      m_h = 0;
      m_bp = ~m_bp;
      m_line = (m_line == FRAME - 1) ? 0 : m_line + 1;
    end else begin
      m_h++;
    end
    #1;
    if (sb.size() == 0) begin
      nerr++; nchecks++;
      $display("FAIL scoreboard_empty at cycle %0d", cyc);
    end else begin
      e = sb.pop_front();
      cur_line = e.line;
      cur_h = e.h;
      cyc++;
      check("scoreboard", sample(), e.o);
    end
  endtask

  task automatic run_until(input int line, input int h);
    int budget = 70000;
    while (!(cur_line == line && cur_h == h) && budget > 0) begin
      cycle();
      budget--;
    end
    if (budget == 0) begin
      nerr++; nchecks++;
      $display("FAIL timeout waiting for line %0d h %0d: got line %0d h %0d", line, h, cur_line, cur_h);
    end
  endtask

  localparam outs_t RST_OUTS = '{scp: 4'd0, sync: 1'b0, blank: 1'b1, burst: 1'b0,
                                 bph: 1'b1, act: 1'b0, px: 12'd0, ln: 10'd0,
                                 fld: 1'b0, fs: 1'b0};
  localparam outs_t ORIGIN   = '{scp: 4'd0, sync: 1'b1, blank: 1'b1, burst: 1'b0,
                                 bph: 1'b1, act: 1'b0, px: 12'd0, ln: 10'd0,
                                 fld: 1'b0, fs: 1'b1};

  initial begin
    outs_t w;
    outs_t got;
    //          line  h   scp sy bl bu ac px  bph
    tbl[0]  = '{0,    0,   0, 1, 1, 0, 0, 0,   1};
    tbl[1]  = '{0,    84,  4, 1, 1, 0, 0, 0,   1};
    tbl[2]  = '{0,    85,  5, 0, 1, 0, 0, 0,   1};
    tbl[3]  = '{0,    100, 4, 1, 1, 0, 0, 0,   1};
    tbl[4]  = '{2,    99,  3, 0, 1, 0, 0, 0,   1};
    tbl[5]  = '{2,    100, 4, 1, 1, 0, 0, 0,   1};
    tbl[6]  = '{2,    106, 10, 1, 1, 0, 0, 0,  1};
    tbl[7]  = '{2,    107, 11, 0, 1, 0, 0, 0,  1};
    tbl[8]  = '{4,    18,  2, 0, 1, 0, 0, 0,   1};
    tbl[9]  = '{5,    18,  10, 0, 1, 1, 0, 0,  0};
    tbl[10] = '{10,   0,   0, 1, 1, 0, 0, 0,   1};
    tbl[11] = '{10,   13,  13, 1, 1, 0, 0, 0,  1};
    tbl[12] = '{10,   14,  14, 0, 1, 0, 0, 0,  1};
    tbl[13] = '{10,   17,  1, 0, 1, 0, 0, 0,   1};
    tbl[14] = '{10,   18,  2, 0, 1, 1, 0, 0,   1};
    tbl[15] = '{10,   25,  9, 0, 1, 1, 0, 0,   1};
    tbl[16] = '{10,   26,  10, 0, 1, 0, 0, 0,  1};
    tbl[17] = '{10,   100, 4, 0, 1, 0, 0, 0,   1};
    tbl[18] = '{23,   18,  10, 0, 1, 1, 0, 0,  0};
    tbl[19] = '{23,   39,  15, 0, 1, 0, 0, 0,  0};
    tbl[20] = '{23,   40,  0, 0, 0, 0, 1, 0,   0};
    tbl[21] = '{23,   193, 9, 0, 0, 0, 1, 153, 0};
    tbl[22] = '{23,   194, 10, 0, 1, 0, 0, 0,  0};
    tbl[23] = '{24,   0,   0, 1, 1, 0, 0, 0,   1};
    tbl[24] = '{309,  18,  10, 0, 1, 1, 0, 0,  0};
    tbl[25] = '{309,  50,  10, 0, 0, 0, 1, 10, 0};
    tbl[26] = '{309,  100, 12, 1, 1, 0, 0, 0,  0};
    tbl[27] = '{309,  150, 14, 0, 1, 0, 0, 0,  0};
    tbl[28] = '{311,  199, 15, 0, 1, 0, 0, 0,  0};

    // Asynchronous reset assertion before any clock edge.
    resetN = 1'b1;
    #1 resetN = 1'b0;
    #1 check("reset_async", sample(), RST_OUTS);
    @(negedge phaseClock);
    check("reset_held", sample(), RST_OUTS);
    model_reset();
    resetN = 1'b1;

    cycle();
    check("first_cycle", sample(), ORIGIN);

    for (int i = 0; i < 29; i++) begin
      run_until(tbl[i].line, tbl[i].h);
      w.scp   = 4'(tbl[i].scp);
      w.sync  = tbl[i].sync;
      w.blank = tbl[i].blank;
      w.burst = tbl[i].burst;
      w.bph   = tbl[i].bph;
      w.act   = tbl[i].act;
      w.px    = 12'(tbl[i].px);
      w.ln    = 10'(tbl[i].line);
      w.fld   = 1'b0;
      w.fs    = (tbl[i].line == 0 && tbl[i].h == 0);
      check($sformatf("vec%0d", i), sample(), w);
    end

    // Progressive frame wrap: origin again after exactly 312 lines.
    run_until(0, 0);
    got = sample();
    check("frame_wrap", got, ORIGIN);
    nchecks++;
    if (cyc - 1 != 62400) begin
      nerr++;
      $display("FAIL frame_length: got %0d clocks required 62400", cyc - 1);
    end

    // Mid-frame reset between edges, then restart from the origin.
    run_until(30, 120);
    #2 resetN = 1'b0;
    #1 check("midframe_reset_async", sample(), RST_OUTS);
    @(posedge phaseClock);
    #1 check("midframe_reset_held", sample(), RST_OUTS);
    @(negedge phaseClock);
    model_reset();
    cur_line = -1; cur_h = -1;
    resetN = 1'b1;
    cycle();
    check("restart_origin", sample(), ORIGIN);
    run_until(1, 20);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
